// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction, Alu and result signal bundle for alu_issue_ctrl
interface alu_issue_ctrl_if;
    // Instruction/operand offer from the register-file read stage
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    // Alu port set
    logic [31:0] a_data;
    logic [31:0] b_data;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic        alu_zero;

    // Result toward writeback
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_zero;
    logic        res_illegal;

    // Controller view
    modport master (
        input  instr_valid, opcode, funct, imm, rs_data, rt_data,
        input  alu_out, alu_zero, res_ready,
        output instr_ready, a_data, b_data, alu_op,
        output res_valid, res_data, res_zero, res_illegal
    );

    // Environment view: instruction source, Alu and result consumer
    modport slave (
        output instr_valid, opcode, funct, imm, rs_data, rt_data,
        output alu_out, alu_zero, res_ready,
        input  instr_ready, a_data, b_data, alu_op,
        input  res_valid, res_data, res_zero, res_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - decodes one MIPS ALU instruction, drives the Alu, returns its result
module alu_issue_ctrl #(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.master  bus
);

    // Alu operation codes
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    // Opcodes understood by this controller
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;

    // R-type function codes
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    // Wait count loaded on accept; a zero-latency Alu captures on the very next edge
    localparam logic [2:0] CNT_INIT = 3'(ALU_LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  cnt;

    logic        dec_illegal;
    logic [3:0]  dec_op;
    logic [31:0] dec_b;

    // Decode the offered instruction into an Alu operation and its second operand
    always_comb begin
        dec_illegal = 1'b0;
        dec_op      = OP_AND;
        dec_b       = bus.rt_data;
        case (bus.opcode)
            OPC_RTYPE: begin
                case (bus.funct)
                    FN_AND:  dec_op = OP_AND;
                    FN_OR:   dec_op = OP_OR;
                    FN_ADD:  dec_op = OP_ADD;
                    FN_SUB:  dec_op = OP_SUB;
                    FN_SLT:  dec_op = OP_SLT;
                    FN_NOR:  dec_op = OP_NOR;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_ADDI: begin
                dec_op = OP_ADDI;
                dec_b  = {{16{bus.imm[15]}}, bus.imm};
            end
            OPC_ANDI: begin
                dec_op = OP_AND;
                dec_b  = {16'h0000, bus.imm};
            end
            OPC_ORI: begin
                dec_op = OP_OR;
                dec_b  = {16'h0000, bus.imm};
            end
            // Branch compare: the Alu zero flag is the taken indication
            OPC_BEQ: begin
                dec_op = OP_SUB;
                dec_b  = bus.rt_data;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Issue FSM: every interface output is a register so the Alu and consumer see glitch-free values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= 3'd0;
            bus.instr_ready <= 1'b1;
            bus.a_data      <= 32'd0;
            bus.b_data      <= 32'd0;
            bus.alu_op      <= OP_AND;
            bus.res_valid   <= 1'b0;
            bus.res_data    <= 32'd0;
            bus.res_zero    <= 1'b0;
            bus.res_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        bus.instr_ready <= 1'b0;
                        if (dec_illegal) begin
                            // Alu inputs are left alone; the result is returned without executing
                            bus.res_illegal <= 1'b1;
                            bus.res_data    <= 32'd0;
                            bus.res_zero    <= 1'b0;
                            bus.res_valid   <= 1'b1;
                            state           <= RESP;
                        end else begin
                            bus.a_data <= bus.rs_data;
                            bus.b_data <= dec_b;
                            bus.alu_op <= dec_op;
                            cnt        <= CNT_INIT;
                            state      <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 3'd0) begin
                        bus.res_data    <= bus.alu_out;
                        bus.res_zero    <= bus.alu_zero;
                        bus.res_illegal <= 1'b0;
                        bus.res_valid   <= 1'b1;
                        state           <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    // Ready rises only after the retire edge, leaving one idle bubble
                    if (bus.res_ready) begin
                        bus.res_valid   <= 1'b0;
                        bus.instr_ready <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: begin
                    bus.res_valid   <= 1'b0;
                    bus.instr_ready <= 1'b1;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with a one-cycle Alu model
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_ctrl_if bus();

    alu_issue_ctrl #(.ALU_LATENCY(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Alu with one registered stage
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        bus.alu_out  <= alu_f(bus.a_data, bus.b_data, bus.alu_op);
        bus.alu_zero <= (alu_f(bus.a_data, bus.b_data, bus.alu_op) == 32'd0);
    end

    typedef struct {
        string       name;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_data;
        logic        exp_zero;
        logic        exp_illegal;
        logic [3:0]  exp_op;
        int          hold;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   retired = 0;
    vec_t sb[$];
    vec_t vecs[15];
    vec_t bb[3];

    function automatic vec_t mk(input string name, input logic [5:0] opc, input logic [5:0] fn,
                                input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] d, input logic z, input logic il,
                                input logic [3:0] op, input int hold);
        vec_t v;
        v.name = name; v.opcode = opc; v.funct = fn; v.imm = imm; v.rs = rs; v.rt = rt;
        v.exp_data = d; v.exp_zero = z; v.exp_illegal = il; v.exp_op = op; v.hold = hold;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare every retired result against the oldest expectation
    always @(negedge clk) begin
        if (!rst && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got data 0x%08h with empty scoreboard", bus.res_data);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk({e.name, "_data"}, bus.res_data, e.exp_data);
                chk({e.name, "_zero"}, {31'd0, bus.res_zero}, {31'd0, e.exp_zero});
                chk({e.name, "_illegal"}, {31'd0, bus.res_illegal}, {31'd0, e.exp_illegal});
                retired++;
            end
        end
    end

    task automatic drive(input vec_t v);
        bus.opcode  = v.opcode;
        bus.funct   = v.funct;
        bus.imm     = v.imm;
        bus.rs_data = v.rs;
        bus.rt_data = v.rt;
    endtask

    // Returns 1 when instr_ready is seen at a negedge within the budget
    task automatic wait_ready(output bit ok);
        int t;
        t = 0;
        ok = 1'b0;
        while (t < 50) begin
            @(negedge clk);
            if (bus.instr_ready) begin
                ok = 1'b1;
                return;
            end
            t++;
        end
    endtask

    // One instruction: accept, latency, decode, optional backpressure, retire and bubble
    task automatic issue(input vec_t v);
        bit          ok;
        int          t;
        logic [3:0]  prev_op;
        logic [31:0] sd;
        logic        sz, si;
        @(posedge clk); #1;
        drive(v);
        bus.res_ready   = 1'b0;
        bus.instr_valid = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            chk({v.name, "_accept_timeout"}, 32'd0, 32'd1);
            bus.instr_valid = 1'b0;
            return;
        end
        prev_op = bus.alu_op;
        sb.push_back(v);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!bus.res_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({v.name, "_latency"}, t, v.exp_illegal ? 32'd0 : 32'd2);
        if (v.exp_illegal)
            chk({v.name, "_alu_op_kept"}, {28'd0, bus.alu_op}, {28'd0, prev_op});
        else begin
            chk({v.name, "_alu_op"}, {28'd0, bus.alu_op}, {28'd0, v.exp_op});
            chk({v.name, "_a_data"}, bus.a_data, v.rs);
        end
        sd = bus.res_data; sz = bus.res_zero; si = bus.res_illegal;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk({v.name, "_hold_valid"}, {31'd0, bus.res_valid}, 32'd1);
            chk({v.name, "_hold_data"}, bus.res_data, sd);
            chk({v.name, "_hold_flags"}, {30'd0, bus.res_zero, bus.res_illegal}, {30'd0, sz, si});
            chk({v.name, "_hold_ready"}, {31'd0, bus.instr_ready}, 32'd0);
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk({v.name, "_no_ready_at_retire"}, {31'd0, bus.instr_ready}, 32'd0);
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        @(negedge clk);
        chk({v.name, "_ready_after_retire"}, {31'd0, bus.instr_ready}, 32'd1);
        chk({v.name, "_valid_after_retire"}, {31'd0, bus.res_valid}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_data"}, bus.a_data, 32'd0);
        chk({tag, "_b_data"}, bus.b_data, 32'd0);
        chk({tag, "_alu_op"}, {28'd0, bus.alu_op}, 32'd0);
        chk({tag, "_res_data"}, bus.res_data, 32'd0);
        chk({tag, "_res_flags"}, {29'd0, bus.res_valid, bus.res_zero, bus.res_illegal}, 32'd0);
    endtask

    task automatic release_and_watch(input string tag);
        int seen;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, bus.instr_ready}, 32'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.res_valid) seen++;
        end
        chk({tag, "_no_stale_valid"}, seen, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit ok;
        int base;
        vec_t rv;

        vecs[0]  = mk("and",   6'b000000, 6'b100100, 16'h0000, 32'd7, 32'd5, 32'd5, 1'b0, 1'b0, 4'b0000, 0);
        vecs[1]  = mk("or",    6'b000000, 6'b100101, 16'h0000, 32'd7, 32'd5, 32'd7, 1'b0, 1'b0, 4'b0001, 0);
        vecs[2]  = mk("add",   6'b000000, 6'b100000, 16'h0000, 32'd7, 32'd5, 32'd12, 1'b0, 1'b0, 4'b0010, 0);
        vecs[3]  = mk("sub",   6'b000000, 6'b100010, 16'h0000, 32'd7, 32'd5, 32'd2, 1'b0, 1'b0, 4'b0110, 0);
        vecs[4]  = mk("nor",   6'b000000, 6'b100111, 16'h0000, 32'd7, 32'd5, 32'hFFFF_FFF8, 1'b0, 1'b0, 4'b1100, 0);
        vecs[5]  = mk("slt_lt", 6'b000000, 6'b101010, 16'h0000, 32'd5, 32'd7, 32'd1, 1'b0, 1'b0, 4'b0111, 0);
        vecs[6]  = mk("slt_ge", 6'b000000, 6'b101010, 16'h0000, 32'd7, 32'd5, 32'd0, 1'b1, 1'b0, 4'b0111, 0);
        vecs[7]  = mk("addi",  6'b001000, 6'b000000, 16'hFFFF, 32'd7, 32'd99, 32'd6, 1'b0, 1'b0, 4'b0011, 0);
        vecs[8]  = mk("andi",  6'b001100, 6'b000000, 16'h0F0F, 32'hFFFF_00FF, 32'd0, 32'h0000_000F, 1'b0, 1'b0, 4'b0000, 0);
        vecs[9]  = mk("ori",   6'b001101, 6'b000000, 16'h8000, 32'd0, 32'd0, 32'h0000_8000, 1'b0, 1'b0, 4'b0001, 0);
        vecs[10] = mk("beq_eq", 6'b000100, 6'b000000, 16'h0003, 32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0, 4'b0110, 0);
        vecs[11] = mk("beq_ne", 6'b000100, 6'b000000, 16'h0003, 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'b0110, 0);
        vecs[12] = mk("ill_opc", 6'b000010, 6'b100000, 16'h1234, 32'd7, 32'd5, 32'd0, 1'b0, 1'b1, 4'b0000, 0);
        vecs[13] = mk("ill_fn", 6'b000000, 6'b000000, 16'h0000, 32'd7, 32'd5, 32'd0, 1'b0, 1'b1, 4'b0000, 0);
        vecs[14] = mk("bp_add", 6'b000000, 6'b100000, 16'h0000, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 4'b0010, 5);

        bb[0] = mk("b2b_add", 6'b000000, 6'b100000, 16'h0000, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 4'b0010, 0);
        bb[1] = mk("b2b_sub", 6'b000000, 6'b100010, 16'h0000, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 4'b0110, 0);
        bb[2] = mk("b2b_ori", 6'b001101, 6'b000000, 16'h0001, 32'd8, 32'd0, 32'd9, 1'b0, 1'b0, 4'b0001, 0);

        bus.instr_valid = 1'b0;
        bus.res_ready   = 1'b0;
        drive(vecs[0]);

        // Reset state
        #12;
        chk_reset_outputs("reset");
        chk("reset_ready", {31'd0, bus.instr_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven single instructions
        for (int i = 0; i < 15; i++) issue(vecs[i]);

        // Back-to-back offers with the consumer always ready
        base = retired;
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(bb[i]);
            bus.instr_valid = 1'b1;
            wait_ready(ok);
            if (!ok) chk("b2b_accept_timeout", 32'd0, 32'd1);
            else sb.push_back(bb[i]);
            @(posedge clk); #1;
        end
        bus.instr_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("b2b_count", retired - base, 32'd3);
        chk("b2b_drained", sb.size(), 32'd0);
        @(posedge clk); #1;
        bus.res_ready = 1'b0;

        // Reset while executing
        rv = mk("rst_exec", 6'b000000, 6'b100000, 16'h0000, 32'd7, 32'd5, 32'd12, 1'b0, 1'b0, 4'b0010, 0);
        drive(rv);
        bus.instr_valid = 1'b1;
        wait_ready(ok);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        chk("rst_exec_busy", {31'd0, bus.instr_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_exec");
        release_and_watch("rst_exec");

        // Reset while holding a result
        rv = mk("rst_resp", 6'b000000, 6'b100101, 16'h0000, 32'd6, 32'd9, 32'd15, 1'b0, 1'b0, 4'b0001, 0);
        drive(rv);
        bus.instr_valid = 1'b1;
        wait_ready(ok);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_resp_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("rst_resp_data", bus.res_data, 32'd15);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_resp");
        release_and_watch("rst_resp");

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
